// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the I/D memory port arbiter.
// No logic; sizes, FSM states and owner encoding.
// Imported by the arbiter top and its starve counter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    MEM_SIZE_BYTE = 2'b00,
    MEM_SIZE_HALF = 2'b01,
    MEM_SIZE_WORD = 2'b10
  } mem_access_size_t;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_REQ,
    ARB_RESP
  } arb_state_t;

  typedef enum logic {
    ARB_OWNER_I,
    ARB_OWNER_D
  } arb_owner_t;

  // Wide enough for the largest allowed STARVE_MAX (15).
  localparam int unsigned STARVE_CNT_W = 4;

endpackage

// File: rtl/mem_port_arbiter_starve_counter.sv
// Counts consecutive D wins while I waits; full_o hands the next arbitration to I.
// Latency: full_o is registered, updates the cycle after inc_i/clr_i.
// Backpressure: none; saturates at MAX, clr_i has priority over inc_i.
module arb_starve_counter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned MAX = 4
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic inc_i,
  input  logic clr_i,
  output logic full_o
);

  localparam logic [STARVE_CNT_W-1:0] MAX_C = STARVE_CNT_W'(MAX);

  logic [STARVE_CNT_W-1:0] cnt_q, cnt_d;

  assign full_o = (cnt_q >= MAX_C);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !full_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch (I) and load/store (D), D priority with I anti-starvation.
// Latency: gnt same cycle as req in IDLE, mem_req_o next cycle, rvalid same cycle as mem_rvalid_i.
// Backpressure: one transaction outstanding; requesters wait with no gnt, REQ holds until mem_gnt_i.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              i_req_i,
  input  logic [ADDR_W-1:0] i_addr_i,
  output logic              i_gnt_o,
  output logic              i_rvalid_o,
  output logic [DATA_W-1:0] i_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [1:0]        d_size_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [1:0]        mem_size_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              err_o
);

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        size;
    logic [DATA_W-1:0] wdata;
  } req_t;

  arb_state_t state_q, state_d;
  arb_owner_t owner_q, owner_d;
  req_t       req_q, req_d;
  logic       err_q, err_d;
  logic       starve_inc, starve_clr, starve_full;
  logic       resp_fire;

  arb_starve_counter #(
    .MAX (STARVE_MAX)
  ) u_starve (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .inc_i    (starve_inc),
    .clr_i    (starve_clr),
    .full_o   (starve_full)
  );

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    req_d      = req_q;
    err_d      = err_q;
    i_gnt_o    = 1'b0;
    d_gnt_o    = 1'b0;
    starve_inc = 1'b0;
    starve_clr = 1'b0;
    resp_fire  = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (mem_rvalid_i || mem_gnt_i) err_d = 1'b1;
        if (d_req_i && (!i_req_i || !starve_full)) begin
          d_gnt_o    = 1'b1;
          owner_d    = ARB_OWNER_D;
          req_d      = '{we: d_we_i, addr: d_addr_i, size: d_size_i, wdata: d_wdata_i};
          starve_inc = i_req_i;
          state_d    = ARB_REQ;
        end else if (i_req_i) begin
          i_gnt_o    = 1'b1;
          owner_d    = ARB_OWNER_I;
          req_d      = '{we: 1'b0, addr: i_addr_i, size: MEM_SIZE_WORD, wdata: '0};
          starve_clr = 1'b1;
          state_d    = ARB_REQ;
        end
      end
      ARB_REQ: begin
        if (mem_rvalid_i) err_d = 1'b1;
        if (mem_gnt_i) state_d = ARB_RESP;
      end
      ARB_RESP: begin
        if (mem_gnt_i) err_d = 1'b1;
        if (mem_rvalid_i) begin
          resp_fire = 1'b1;
          state_d   = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Memory side sees only latched fields, and zeros outside REQ.
  assign mem_req_o   = (state_q == ARB_REQ);
  assign mem_we_o    = mem_req_o & req_q.we;
  assign mem_addr_o  = mem_req_o ? req_q.addr  : '0;
  assign mem_size_o  = mem_req_o ? req_q.size  : '0;
  assign mem_wdata_o = mem_req_o ? req_q.wdata : '0;

  assign i_rvalid_o = resp_fire && (owner_q == ARB_OWNER_I);
  assign d_rvalid_o = resp_fire && (owner_q == ARB_OWNER_D);
  assign i_rdata_o  = i_rvalid_o ? mem_rdata_i : '0;
  assign d_rdata_o  = d_rvalid_o ? mem_rdata_i : '0;
  assign err_o      = err_q;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= ARB_IDLE;
      owner_q <= ARB_OWNER_I;
      req_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      req_q   <= req_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expected grant/response events,
// a negedge monitor pops and compares them; direct checks cover mem fields, reset and err_o.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic        clk_i = 1'b0;
  logic        reset_ni = 1'b0;
  logic        i_req_i = 1'b0;
  logic [31:0] i_addr_i = '0;
  logic        i_gnt_o, i_rvalid_o;
  logic [31:0] i_rdata_o;
  logic        d_req_i = 1'b0;
  logic        d_we_i = 1'b0;
  logic [31:0] d_addr_i = '0;
  logic [1:0]  d_size_i = 2'b10;
  logic [31:0] d_wdata_i = '0;
  logic        d_gnt_o, d_rvalid_o;
  logic [31:0] d_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o;
  logic [1:0]  mem_size_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        err_o;

  mem_port_arbiter #(.STARVE_MAX(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni),
    .i_req_i(i_req_i), .i_addr_i(i_addr_i), .i_gnt_o(i_gnt_o),
    .i_rvalid_o(i_rvalid_o), .i_rdata_o(i_rdata_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_size_i(d_size_i),
    .d_wdata_i(d_wdata_i), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_size_o(mem_size_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef enum {EV_GNT_I, EV_GNT_D, EV_RV_I, EV_RV_D} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    logic [31:0] data;
  } ev_t;
  ev_t exp_q[$];

  task automatic push_ev(input ev_kind_t k, input logic [31:0] d);
    ev_t e;
    e.kind = k;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  task automatic expect_ev(input ev_kind_t k, input logic [31:0] d, input logic [31:0] other);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected event %s data=%h at cycle %0d", k.name(), d, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.data !== d || other !== 32'h0) begin
        bad++;
        $display("FAIL event: got %s data=%h other_rdata=%h, want %s data=%h other_rdata=0 (cycle %0d)",
                 k.name(), d, other, e.kind.name(), e.data, cyc);
      end
    end
  endtask

  // Monitor: every grant/response the DUT presents must match the next expected event.
  always @(negedge clk_i) begin
    if (i_gnt_o)    expect_ev(EV_GNT_I, 32'h0, 32'h0);
    if (d_gnt_o)    expect_ev(EV_GNT_D, 32'h0, 32'h0);
    if (i_rvalid_o) expect_ev(EV_RV_I, i_rdata_o, d_rdata_o);
    if (d_rvalid_o) expect_ev(EV_RV_D, d_rdata_o, i_rdata_o);
  end

  // Memory model: grants after 'stall' cycles of mem_req_o, responds next cycle with addr^0x00010013.
  bit          model_en = 1'b1;
  int          stall = 0;
  bit          pend = 1'b0;
  logic [31:0] pend_data = '0;
  initial forever begin
    @(posedge clk_i);
    #1;
    if (model_en) begin
      mem_gnt_i = 1'b0;
      mem_rvalid_i = 1'b0;
      mem_rdata_i = '0;
      if (pend) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i = pend_data;
        pend = 1'b0;
      end else if (mem_req_o) begin
        if (stall > 0) begin
          stall--;
        end else begin
          mem_gnt_i = 1'b1;
          pend = 1'b1;
          pend_data = mem_addr_o ^ 32'h0001_0013;
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_gnt(input bit is_d, input string name);
    bit seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk_i);
      seen = is_d ? d_gnt_o : i_gnt_o;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL %s: no grant within 40 cycles", name);
    end
  endtask

  task automatic wait_any_gnt(input string name);
    bit seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk_i);
      seen = i_gnt_o | d_gnt_o;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL %s: no grant within 40 cycles", name);
    end
  endtask

  task automatic do_fetch(input logic [31:0] addr, input logic [31:0] data, input string name);
    push_ev(EV_GNT_I, 32'h0);
    push_ev(EV_RV_I, data);
    tick;
    i_req_i = 1'b1;
    i_addr_i = addr;
    wait_gnt(1'b0, name);
    tick;
    i_req_i = 1'b0;
    repeat (2) @(negedge clk_i);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] b2b_addr [3] = '{32'h0001_0004, 32'h0001_0008, 32'h0001_000C};
  logic [31:0] b2b_data [3] = '{32'h0000_0017, 32'h0000_001B, 32'h0000_001F};
  int last_gnt;

  initial begin
    // Reset state
    repeat (2) @(negedge clk_i);
    check("reset ctl", {i_gnt_o, i_rvalid_o, d_gnt_o, d_rvalid_o, mem_req_o, mem_we_o, err_o}, 7'h0);
    check("reset mem fields", {mem_addr_o, mem_size_o, mem_wdata_o}, 66'h0);
    tick;
    reset_ni = 1'b1;

    // Single I read, zero-wait memory
    push_ev(EV_GNT_I, 32'h0);
    push_ev(EV_RV_I, 32'h0000_0013);
    tick;
    i_req_i = 1'b1;
    i_addr_i = 32'h0001_0000;
    wait_gnt(1'b0, "t1 gnt");
    tick;
    i_req_i = 1'b0;
    i_addr_i = 32'hFFFF_FFFF;
    @(negedge clk_i);
    check("t1 mem_req", {mem_req_o, mem_addr_o}, {1'b1, 32'h0001_0000});
    check("t1 size/we", {mem_size_o, mem_we_o}, {2'b10, 1'b0});
    @(negedge clk_i);
    check("t1 rvalid latency", i_rvalid_o, 1'b1);

    // Back-to-back fetches with i_req_i held
    for (int k = 0; k < 3; k++) begin
      push_ev(EV_GNT_I, 32'h0);
      push_ev(EV_RV_I, b2b_data[k]);
    end
    tick;
    i_req_i = 1'b1;
    last_gnt = 0;
    for (int k = 0; k < 3; k++) begin
      i_addr_i = b2b_addr[k];
      wait_gnt(1'b0, "t2 gnt");
      if (k > 0) check("t2 gnt spacing", 96'(cyc - last_gnt), 96'd3);
      last_gnt = cyc;
      tick;
    end
    i_req_i = 1'b0;
    repeat (3) @(negedge clk_i);

    // D byte store, memory stalls grant for 3 cycles
    push_ev(EV_GNT_D, 32'h0);
    push_ev(EV_RV_D, 32'h0001_0113);
    stall = 3;
    tick;
    d_req_i = 1'b1;
    d_we_i = 1'b1;
    d_addr_i = 32'h0000_0100;
    d_size_i = 2'b00;
    d_wdata_i = 32'h0000_00AB;
    wait_gnt(1'b1, "t3 gnt");
    tick;
    d_req_i = 1'b0;
    d_addr_i = 32'hDEAD_BEEF;
    d_wdata_i = 32'h0;
    d_we_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      check("t3 held fields", {mem_req_o, mem_we_o, mem_size_o, mem_addr_o, mem_wdata_o},
            {1'b1, 1'b1, 2'b00, 32'h0000_0100, 32'h0000_00AB});
    end
    @(negedge clk_i);
    check("t3 ack", {d_rvalid_o, i_rvalid_o, mem_req_o}, 3'b100);

    // Both requesters held: D,D,D,D,I,D,D,D,D,I
    for (int n = 0; n < 10; n++) begin
      if (n == 4 || n == 9) begin
        push_ev(EV_GNT_I, 32'h0);
        push_ev(EV_RV_I, 32'h0000_0013);
      end else begin
        push_ev(EV_GNT_D, 32'h0);
        push_ev(EV_RV_D, 32'h0001_0213);
      end
    end
    tick;
    d_we_i = 1'b0;
    d_size_i = 2'b10;
    d_addr_i = 32'h0000_0200;
    i_addr_i = 32'h0001_0000;
    i_req_i = 1'b1;
    d_req_i = 1'b1;
    for (int n = 0; n < 10; n++) begin
      wait_any_gnt("t4 gnt");
      if (n < 9) tick;
    end
    tick;
    i_req_i = 1'b0;
    d_req_i = 1'b0;
    repeat (3) @(negedge clk_i);

    // Reset between mem_gnt_i and mem_rvalid_i drops the transaction
    model_en = 1'b0;
    push_ev(EV_GNT_I, 32'h0);
    tick;
    mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b0;
    i_req_i = 1'b1;
    i_addr_i = 32'h0001_0040;
    wait_gnt(1'b0, "t5 gnt");
    tick;
    i_req_i = 1'b0;
    mem_gnt_i = 1'b1;
    tick;
    mem_gnt_i = 1'b0;
    @(negedge clk_i);
    #1;
    reset_ni = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i = 32'hFFFF_FFFF;
    #1;
    check("t5 async reset outputs",
          {i_gnt_o, i_rvalid_o, d_gnt_o, d_rvalid_o, mem_req_o, err_o, i_rdata_o, d_rdata_o}, 70'h0);
    tick;
    mem_rvalid_i = 1'b0;
    mem_rdata_i = '0;
    tick;
    reset_ni = 1'b1;
    repeat (3) @(negedge clk_i);
    check("t5 idle after release", {mem_req_o, err_o, i_rvalid_o}, 3'b000);
    model_en = 1'b1;

    // Spurious response in IDLE: ignored, err_o sticky
    model_en = 1'b0;
    tick;
    mem_rvalid_i = 1'b1;
    mem_rdata_i = 32'h5A5A_5A5A;
    @(negedge clk_i);
    check("t6 no rvalid", {i_rvalid_o, d_rvalid_o, i_rdata_o, d_rdata_o}, 66'h0);
    tick;
    mem_rvalid_i = 1'b0;
    mem_rdata_i = '0;
    @(negedge clk_i);
    check("t6 err set", err_o, 1'b1);
    model_en = 1'b1;
    do_fetch(32'h0001_0080, 32'h0000_0093, "t6 fetch");
    check("t6 err sticky", err_o, 1'b1);

    // Reset clears err_o; spurious mem_gnt_i in IDLE sets it again
    tick;
    reset_ni = 1'b0;
    @(negedge clk_i);
    check("t7 err cleared", err_o, 1'b0);
    tick;
    reset_ni = 1'b1;
    model_en = 1'b0;
    tick;
    mem_gnt_i = 1'b1;
    tick;
    mem_gnt_i = 1'b0;
    @(negedge clk_i);
    check("t7 gnt in idle", {err_o, mem_req_o}, 2'b10);
    model_en = 1'b1;
    do_fetch(32'h0001_00C0, 32'h0000_00D3, "t7 fetch");

    repeat (3) @(negedge clk_i);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard drain: got %0d pending events want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
